imem_loader: RTL
================

# imem_loader

Front-panel program loader that sits directly upstream of the instruction memory in the processor top level. It debounces the five push keys, captures the 16 dip switches as instruction words, and drives the memory address, data and write-enable lines to fill the memory one word at a time. It shows the read-back word on the LEDs. In RUN mode it hands the address port over to the processor's program counter.

## Interface

- DEBOUNCE_CYCLES, 500000, cycles a key must be stable before it is accepted (10 ms at 50 MHz)
- ADDR_W, 8, memory address width
- DATA_W, 16, instruction word width
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- dip  in  DATA_W  switch word to be written
- key  in  5  raw push keys, active-high, asynchronous to clk
- pc  in  ADDR_W  processor fetch address, used in RUN
- dout  in  DATA_W  memory read data, one-cycle read latency
- addr  out  ADDR_W  memory address (ADDRA)
- din  out  DATA_W  memory write data (DINA)
- we  out  1  memory write enable (WEA), single-cycle pulse
- led  out  DATA_W  display word
- run  out  1  high in RUN mode (processor enable)

## Operation

- Each key passes through a 2-flop synchronizer and then a stability counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - A one-cycle press pulse is generated on each debounced rising edge.
- Key map:
  - key[0] WRITE: store dip at cur, then cur+1.
  - key[1] NEXT: cur+1.
  - key[2] PREV: cur-1.
  - key[3] HOME: cur=0.
  - key[4] MODE: toggle LOAD/RUN.
- Simultaneous pulses in one cycle: only the highest priority acts. Priority order is key[4] > key[3] > key[0] > key[1] > key[2]. The others are dropped.
- FSM states:
  - LOAD_IDLE:
    - WRITE goes to WR, with din_r <= dip.
    - NEXT, PREV and HOME update cur and stay in LOAD_IDLE.
    - MODE goes to RUN.
  - WR: we=1, addr=cur, din=din_r. Always goes to ADV the next cycle.
  - ADV: cur <= cur+1, then goes to LOAD_IDLE.
  - RUN:
    - addr=pc, we=0.
    - MODE goes to LOAD_IDLE with cur unchanged.
    - All other keys are ignored.
- Press pulses arriving in WR or ADV are dropped.
- cur arithmetic is modulo 2^ADDR_W. 255+1 wraps to 0 and 0-1 wraps to 255, with no saturation.
- led:
  - In LOAD states, registered: led <= dout.
  - In RUN, led <= {8'h00, pc}.
- run is registered and high exactly in RUN.

## Timing

- Reset values:
  - cur=0, state LOAD_IDLE.
  - addr=0, din=0, we=0, led=0, run=0.
  - All synchronizer, debounced and counter state is 0.
- Key latency: a raw edge that stays stable produces its press pulse 2+DEBOUNCE_CYCLES cycles later (±1 cycle).
- WRITE whose press pulse is at cycle T:
  - we=1 at T+1, with addr=cur and din=dip as sampled at T.
  - addr=cur+1 at T+2; state is LOAD_IDLE at T+3.
- Read-back: led shows mem[addr] two cycles after addr changes. This is one cycle of memory latency plus one cycle of led register.
- RUN:
  - addr follows pc combinationally, with zero added latency.
  - After MODE, run asserts at T+1.
- rst asserted during WR: we=0 on the following cycle, and the memory contents are untouched by the loader.
- Holding a key produces exactly one pulse; a second pulse requires a debounced release followed by a press.

## Structure

- Package imem_loader_pkg holds:
  - key index constants: KEY_WRITE=0, KEY_NEXT=1, KEY_PREV=2, KEY_HOME=3, KEY_MODE=4.
  - the FSM state enum.
  - default ADDR_W/DATA_W.
- Sub-module key_debounce (synchronizer, counter and edge pulse; parameter DEBOUNCE_CYCLES), instantiated once per key.
- The top-level FSM, cur counter and output muxing stay in imem_loader.

## Test plan

Simulate with DEBOUNCE_CYCLES=4 and a one-cycle-latency memory model.

- WRITE at address 0: set dip=16'hA5C3 and press key[0] for 20 cycles.
  - Required: exactly one we pulse with addr=0x00 and din=A5C3.
  - Then addr=0x01, and led=A5C3 after returning to 0x00 via PREV.
- Wrap-around: HOME, then PREV gives addr=0xFF. A WRITE at 0xFF stores the word at 0xFF, and the next addr is 0x00.
- Bounce filtering: toggle key[1] every 2 cycles for 30 cycles, then hold it high.
  - Required: exactly one NEXT, with cur 0→1.
- Priority: key[0] and key[4] pulse in the same cycle.
  - Required: no we, run=1, and addr tracks pc=0x37.
  - A second MODE returns to LOAD with cur unchanged.
- Reset mid-write: assert rst in the WR cycle.
  - Required: next cycle we=0, addr=0, led=0, run=0.
  - A subsequent WRITE works normally.
- Held key: hold key[0] for 200 cycles.
  - Required: one write only.
  - After release and a new press, a second write at cur+1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM state type for the front-panel instruction memory loader.
package imem_loader_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned NUM_KEYS   = 5;

    localparam int unsigned KEY_WRITE = 0;
    localparam int unsigned KEY_NEXT  = 1;
    localparam int unsigned KEY_PREV  = 2;
    localparam int unsigned KEY_HOME  = 3;
    localparam int unsigned KEY_MODE  = 4;

    typedef enum logic [1:0] {
        StLoadIdle,
        StWr,
        StAdv,
        StRun
    } state_e;

endpackage

// File: rtl/imem_loader_key_debounce.sv
// One push key: 2-flop synchronizer, stability counter and a one-cycle pulse on each
// debounced rising edge.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic press_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            deb_q, deb_d;
    logic            press_q, press_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = key_i;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        // Count consecutive samples that disagree with the accepted level; any agreeing
        // sample restarts the count.
        if (sync2_q != deb_q) begin
            if (cnt_q == CntMax) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = deb_d & ~deb_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/imem_loader.sv
// Front-panel loader: debounced keys step a cursor and write dip words into the
// instruction memory; RUN mode hands the address port to the processor PC.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned ADDR_W          = ADDR_W_DEF,
    parameter int unsigned DATA_W          = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] dip,
    input  logic [4:0]        key,
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] din,
    output logic              we,
    output logic [DATA_W-1:0] led,
    output logic              run
);

    logic [NUM_KEYS-1:0] press;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk    (clk),
            .rst    (rst),
            .key_i  (key[i]),
            .press_o(press[i])
        );
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] led_q, led_d;
    logic              run_q, run_d;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        din_d   = din_q;
        case (state_q)
            StLoadIdle: begin
                // Priority chain: MODE > HOME > WRITE > NEXT > PREV.
                if (press[KEY_MODE]) begin
                    state_d = StRun;
                end else if (press[KEY_HOME]) begin
                    cur_d = '0;
                end else if (press[KEY_WRITE]) begin
                    state_d = StWr;
                    din_d   = dip;
                end else if (press[KEY_NEXT]) begin
                    cur_d = cur_q + 1'b1;
                end else if (press[KEY_PREV]) begin
                    cur_d = cur_q - 1'b1;
                end
            end
            StWr: state_d = StAdv;
            StAdv: begin
                cur_d   = cur_q + 1'b1;
                state_d = StLoadIdle;
            end
            StRun: begin
                if (press[KEY_MODE]) begin
                    state_d = StLoadIdle;
                end
            end
            default: state_d = StLoadIdle;
        endcase

        if (state_q == StRun) begin
            led_d = {{(DATA_W - ADDR_W){1'b0}}, pc};
        end else begin
            led_d = dout;
        end
        run_d = (state_d == StRun);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StLoadIdle;
            cur_q   <= '0;
            din_q   <= '0;
            led_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            din_q   <= din_d;
            led_q   <= led_d;
            run_q   <= run_d;
        end
    end

    // ADV already presents the advanced address so read-back starts a cycle early.
    always_comb begin
        case (state_q)
            StRun:   addr = pc;
            StAdv:   addr = cur_q + 1'b1;
            default: addr = cur_q;
        endcase
    end

    assign we  = (state_q == StWr);
    assign din = din_q;
    assign led = led_q;
    assign run = run_q;

endmodule
